// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending-machine state codes, widths and sizing helpers
package vend_pkg;

  localparam int VEND_STATE_W    = 4;
  localparam int VEND_NUM_STATES = 10;

  typedef enum logic [VEND_STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_COIN_5   = 4'd1,
    ST_COIN_10  = 4'd2,
    ST_COIN_15  = 4'd3,
    ST_COIN_20  = 4'd4,
    ST_SEL_A    = 4'd5,
    ST_SEL_B    = 4'd6,
    ST_DISPENSE = 4'd7,
    ST_CHANGE   = 4'd8,
    ST_FAULT    = 4'd9
  } vend_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Select ports are never narrower than one bit, even for a single entry.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/state_hist.sv
// rtl/state_hist.sv - shift-register trace of previous codes with a read mux
module state_hist
  import vend_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int W       = 4,
  parameter int RST_VAL = 0,
  localparam int SEL_W  = sel_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_shift,
  input  logic [W-1:0]     i_din,
  input  logic [SEL_W-1:0] i_sel,
  output logic [W-1:0]     o_dout
);

  localparam logic [W-1:0] LP_RST = RST_VAL[W-1:0];

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] w_dout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= LP_RST;
      end
    end else if (i_shift) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // Out-of-range selects fall through to entry 0.
  always_comb begin
    w_dout = r_mem[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (i_sel == SEL_W'(i)) begin
        w_dout = r_mem[i];
      end
    end
  end

  assign o_dout = w_dout;

endmodule

// File: rtl/state_memory_p.sv
// rtl/state_memory_p.sv - state register with load, illegal-code recovery, dwell timeout and history
module state_memory_p
  import vend_pkg::*;
#(
  parameter int STATE_W     = VEND_STATE_W,
  parameter int NUM_STATES  = VEND_NUM_STATES,
  parameter int RESET_STATE = int'(ST_IDLE),
  parameter int TIMEOUT     = 0,
  parameter int TMR_W       = 16,
  parameter int HIST_DEPTH  = 4,
  localparam int HSEL_W     = sel_w(HIST_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [STATE_W-1:0] i_ns,
  input  logic               i_ld,
  input  logic               i_clr,
  input  logic [HSEL_W-1:0]  i_hist_sel,
  output logic [STATE_W-1:0] o_cs,
  output logic [STATE_W-1:0] o_ps,
  output logic               o_chg,
  output logic               o_ill,
  output logic [TMR_W-1:0]   o_dwell,
  output logic               o_tout,
  output logic [STATE_W-1:0] o_hist_out
);

  localparam logic [STATE_W-1:0] LP_RST     = RESET_STATE[STATE_W-1:0];
  localparam logic [STATE_W:0]   LP_NUM     = NUM_STATES[STATE_W:0];
  localparam bit                 LP_TMO_EN  = (TIMEOUT != 0);
  localparam int                 LP_TMO_M1  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0]   LP_TMO_LST = LP_TMO_M1[TMR_W-1:0];

  logic [STATE_W-1:0] r_cs;
  logic [STATE_W-1:0] r_ps;
  logic               r_chg;
  logic               r_ill;
  logic               r_tout;
  logic [TMR_W-1:0]   r_dwell;

  logic [STATE_W-1:0] w_target;
  logic               w_ns_legal;
  logic               w_expire;
  logic               w_ill_set;
  logic               w_is_tout;
  logic               w_change;

  assign w_ns_legal = ({1'b0, i_ns} < LP_NUM);
  assign w_expire   = LP_TMO_EN && (r_cs != LP_RST) && (r_dwell == LP_TMO_LST);

  // Target selection: clear, illegal load, legal load, timeout, hold.
  always_comb begin
    w_target  = r_cs;
    w_ill_set = 1'b0;
    w_is_tout = 1'b0;
    if (i_clr) begin
      w_target = LP_RST;
    end else if (i_ld && !w_ns_legal) begin
      w_target  = LP_RST;
      w_ill_set = 1'b1;
    end else if (i_ld) begin
      w_target = i_ns;
    end else if (w_expire) begin
      w_target  = LP_RST;
      w_is_tout = 1'b1;
    end
    w_change = (w_target != r_cs);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs    <= LP_RST;
      r_ps    <= LP_RST;
      r_chg   <= 1'b0;
      r_ill   <= 1'b0;
      r_tout  <= 1'b0;
      r_dwell <= '0;
    end else begin
      r_cs   <= w_target;
      r_chg  <= w_change;
      r_tout <= w_is_tout;
      if (w_change) begin
        r_ps    <= r_cs;
        r_dwell <= '0;
      end else if (~&r_dwell) begin
        r_dwell <= r_dwell + 1'b1;
      end
      if (i_clr) begin
        r_ill <= 1'b0;
      end else if (w_ill_set) begin
        r_ill <= 1'b1;
      end
    end
  end

  state_hist #(
    .DEPTH   (HIST_DEPTH),
    .W       (STATE_W),
    .RST_VAL (RESET_STATE)
  ) u_hist (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_shift (w_change),
    .i_din   (r_cs),
    .i_sel   (i_hist_sel),
    .o_dout  (o_hist_out)
  );

  assign o_cs    = r_cs;
  assign o_ps    = r_ps;
  assign o_chg   = r_chg;
  assign o_ill   = r_ill;
  assign o_dwell = r_dwell;
  assign o_tout  = r_tout;

endmodule
